// File: rtl/rf_mode_switch_ctrl.sv
// Mode-pin controller: synchronise and debounce the request, apply it only while the datapath is idle,
// and hold AUX low for the init window and on every stand-by exit. Optional macro: RF_MODE_CTRL_TIMEOUT_EN.
module rf_mode_switch_ctrl #(
    parameter int unsigned MODE_W         = 2,
    parameter int unsigned DEFAULT_MODE   = 3,
    parameter int unsigned STANDBY_MODE   = 3,
    parameter int unsigned INIT_CYCLES    = 10000,
    parameter int unsigned SWITCH_CYCLES  = 10000,
    parameter int unsigned SETTLE_CYCLES  = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              internal_clk,
    input  logic              rst_n,
    input  logic [MODE_W-1:0] mode_req,
    input  logic              AUX_state_ctrl,
    output logic [MODE_W-1:0] mode_sync,
    output logic              AUX_mode_ctrl,
    output logic              mode_changed,
    output logic              switch_pending
`ifdef RF_MODE_CTRL_TIMEOUT_EN
    ,
    output logic              force_switch
`endif
);

    localparam int unsigned MAX_AB  = (INIT_CYCLES > SWITCH_CYCLES) ? INIT_CYCLES : SWITCH_CYCLES;
    localparam int unsigned MAX_CD  = (SETTLE_CYCLES > TIMEOUT_CYCLES) ? SETTLE_CYCLES : TIMEOUT_CYCLES;
    localparam int unsigned CNT_MAX = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [MODE_W-1:0] DEF_M       = MODE_W'(DEFAULT_MODE);
    localparam logic [MODE_W-1:0] STBY_M      = MODE_W'(STANDBY_MODE);
    localparam logic [CNT_W-1:0]  INIT_LAST   = CNT_W'(INIT_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SWITCH_LAST = CNT_W'(SWITCH_CYCLES - 1);
    localparam logic [CNT_W-1:0]  SETTLE_MAX  = CNT_W'(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_INIT   = 2'd0,
        ST_IDLE   = 2'd1,
        ST_SWITCH = 2'd2
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [MODE_W-1:0]  r_sync1, r_req_s, r_stable_req;
    logic [CNT_W-1:0]   r_settle_cnt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [MODE_W-1:0]  r_mode_sync, w_mode_nxt, r_mode_prev;
    logic               r_aux, w_aux_nxt;
    logic               r_mode_changed, r_switch_pending;
    logic               w_want;
    logic               w_allow;

    // Front end: 2-flop synchroniser plus settle counter; stable_req only follows a request held SETTLE_CYCLES
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1      <= DEF_M;
            r_req_s      <= DEF_M;
            r_settle_cnt <= '0;
            r_stable_req <= DEF_M;
        end else begin
            r_sync1 <= mode_req;
            r_req_s <= r_sync1;
            if (r_sync1 != r_req_s) begin
                r_settle_cnt <= '0;
            end else if (r_settle_cnt != SETTLE_MAX) begin
                r_settle_cnt <= r_settle_cnt + CNT_W'(1);
                if (r_settle_cnt == SETTLE_LAST) begin
                    r_stable_req <= r_req_s;
                end
            end
        end
    end

    assign w_want = (r_stable_req != r_mode_sync);

`ifdef RF_MODE_CTRL_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_wait_cnt;
    logic             r_force;
    logic             w_wait_run;
    logic             w_timeout;

    assign w_wait_run = (r_state == ST_IDLE) && r_switch_pending && !AUX_state_ctrl && w_want;
    assign w_timeout  = w_wait_run && (r_wait_cnt == TIMEOUT_LAST);
    assign w_allow    = AUX_state_ctrl || w_timeout;

    // Busy-wait counter; cleared by the switch itself or by the request going away
    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wait_cnt <= '0;
            r_force    <= 1'b0;
        end else begin
            r_force <= w_timeout;
            if (w_wait_run && !w_timeout) begin
                r_wait_cnt <= r_wait_cnt + CNT_W'(1);
            end else begin
                r_wait_cnt <= '0;
            end
        end
    end

    assign force_switch = r_force;
`else
    assign w_allow = AUX_state_ctrl;
`endif

    // Next-state logic; the shared counter times both the init and the stand-by exit windows
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode_sync;
        w_aux_nxt   = r_aux;
        case (r_state)
            ST_INIT: begin
                if (r_cnt == INIT_LAST) begin
                    w_aux_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_IDLE: begin
                if (w_want && w_allow) begin
                    w_mode_nxt = r_stable_req;
                    if ((r_mode_sync == STBY_M) && (r_stable_req != STBY_M)) begin
                        w_aux_nxt   = 1'b0;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_SWITCH;
                    end
                end
            end
            ST_SWITCH: begin
                if (r_cnt == SWITCH_LAST) begin
                    w_aux_nxt   = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = ST_INIT;
                w_cnt_nxt   = '0;
                w_aux_nxt   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge internal_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_INIT;
            r_cnt            <= '0;
            r_mode_sync      <= DEF_M;
            r_mode_prev      <= DEF_M;
            r_aux            <= 1'b0;
            r_mode_changed   <= 1'b0;
            r_switch_pending <= 1'b0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_mode_sync      <= w_mode_nxt;
            r_mode_prev      <= r_mode_sync;
            r_aux            <= w_aux_nxt;
            r_mode_changed   <= (r_mode_sync != r_mode_prev);
            r_switch_pending <= w_want;
        end
    end

    assign mode_sync      = r_mode_sync;
    assign AUX_mode_ctrl  = r_aux;
    assign mode_changed   = r_mode_changed;
    assign switch_pending = r_switch_pending;

endmodule

// File: tb/tb_rf_mode_switch_ctrl.sv
// Self-checking bench for rf_mode_switch_ctrl: directed scenarios plus randomized pins/idle,
// checked every cycle against a deadline/window-based reference model.
module tb_rf_mode_switch_ctrl;

    localparam int DEF     = 3;
    localparam int STBY    = 3;
    localparam int INIT    = 20;
    localparam int SWITCH  = 16;
    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] mode_req;
    logic       aux_state;
    logic [1:0] mode_sync;
    logic       aux_mode;
    logic       mode_changed;
    logic       switch_pending;
    logic       force_switch;

    always #5 clk = ~clk;

    rf_mode_switch_ctrl #(
        .MODE_W(2), .DEFAULT_MODE(DEF), .STANDBY_MODE(STBY), .INIT_CYCLES(INIT),
        .SWITCH_CYCLES(SWITCH), .SETTLE_CYCLES(SETTLE), .TIMEOUT_CYCLES(TIMEOUT)
    ) dut (
        .internal_clk   (clk),
        .rst_n          (rst_n),
        .mode_req       (mode_req),
        .AUX_state_ctrl (aux_state),
        .mode_sync      (mode_sync),
        .AUX_mode_ctrl  (aux_mode),
        .mode_changed   (mode_changed),
        .switch_pending (switch_pending)
`ifdef RF_MODE_CTRL_TIMEOUT_EN
        ,
        .force_switch   (force_switch)
`endif
    );

`ifndef RF_MODE_CTRL_TIMEOUT_EN
    assign force_switch = 1'b0;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: pins appear two edges late; a value held for SETTLE+1 consecutive
    // synchronised samples becomes the stable request; AUX is low until an absolute deadline edge.
    logic [1:0] m_pin_d, m_reqs, m_stable, m_mode, m_mode_prev;
    logic       m_aux, m_changed, m_pending, m_force;
    int         m_n, m_aux_high_at, m_run;
    logic [1:0] m_hist[$];
    logic [1:0] o_stable, o_mode;
    bit         idle, want, busy_wait, tmo, go, all_same;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pin_d = 2'(DEF); m_reqs = 2'(DEF); m_stable = 2'(DEF);
            m_mode = 2'(DEF); m_mode_prev = 2'(DEF);
            m_aux = 0; m_changed = 0; m_pending = 0; m_force = 0;
            m_n = 0; m_aux_high_at = INIT; m_run = 0;
            m_hist = {2'(DEF)};
        end else begin
            o_stable = m_stable;
            o_mode   = m_mode;
            m_n++;
            idle = (m_n > m_aux_high_at);
            want = (o_stable != o_mode);
            busy_wait = idle && m_pending && !aux_state && want;
            m_run = busy_wait ? m_run + 1 : 0;
`ifdef RF_MODE_CTRL_TIMEOUT_EN
            tmo = busy_wait && (m_run == TIMEOUT);
`else
            tmo = 0;
`endif
            go = idle && want && (aux_state || tmo);
            if (go) begin
                m_mode = o_stable;
                m_run  = 0;
                if (o_mode == 2'(STBY) && o_stable != 2'(STBY)) m_aux_high_at = m_n + SWITCH;
            end
            m_aux       = (m_n >= m_aux_high_at);
            m_force     = tmo;
            m_changed   = (o_mode != m_mode_prev);
            m_mode_prev = o_mode;
            m_pending   = want;
            m_reqs  = m_pin_d;
            m_pin_d = mode_req;
            m_hist.push_front(m_reqs);
            if (m_hist.size() > SETTLE + 1) void'(m_hist.pop_back());
            all_same = (m_hist.size() == SETTLE + 1);
            foreach (m_hist[i]) if (m_hist[i] != m_reqs) all_same = 0;
            if (all_same) m_stable = m_reqs;
        end
    end

    // Every-cycle comparison against the model
    always @(posedge clk) begin
        #2;
        check("mode_sync", int'(mode_sync), int'(m_mode));
        check("aux_mode", int'(aux_mode), int'(m_aux));
        check("mode_changed", int'(mode_changed), int'(m_changed));
        check("switch_pending", int'(switch_pending), int'(m_pending));
`ifdef RF_MODE_CTRL_TIMEOUT_EN
        check("force_switch", int'(force_switch), int'(m_force));
`endif
    end

    task automatic wait_edges(input int k);
        repeat (k) begin
            @(posedge clk);
            #1;
        end
    endtask

    int low_cnt, hold, flag;

    initial begin
        rst_n = 1'b0; mode_req = 2'd3; aux_state = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_mode", int'(mode_sync), 3);
        check("rst_aux", int'(aux_mode), 0);
        check("rst_changed", int'(mode_changed), 0);
        check("rst_pending", int'(switch_pending), 0);
        rst_n = 1'b1;
        wait_edges(INIT - 1);
        check("init_aux_still_low", int'(aux_mode), 0);
        wait_edges(1);
        check("init_aux_high", int'(aux_mode), 1);
        check("init_mode", int'(mode_sync), 3);

        // Stand-by exit 3 -> 0: 7-clock latency, 16-clock AUX window
        @(negedge clk); mode_req = 2'd0;
        wait_edges(6);
        check("exit_before_latency", int'(mode_sync), 3);
        wait_edges(1);
        check("exit_mode", int'(mode_sync), 0);
        low_cnt = 0;
        for (int i = 0; i < 40 && !aux_mode; i++) begin
            if (i == 1) check("exit_changed_pulse", int'(mode_changed), 1);
            low_cnt++;
            wait_edges(1);
        end
        check("exit_aux_low_len", low_cnt, SWITCH);

        // Non-standby switch 0 -> 2 keeps AUX high
        @(negedge clk); mode_req = 2'd2;
        flag = 0;
        repeat (7) begin
            wait_edges(1);
            if (!aux_mode) flag = 1;
        end
        check("ns_mode", int'(mode_sync), 2);
        check("ns_aux_drop", flag, 0);
        @(negedge clk); mode_req = 2'd0;
        wait_edges(10);

        // 3-clock glitch is filtered
        @(negedge clk); mode_req = 2'd1;
        repeat (3) @(negedge clk);
        mode_req = 2'd0;
        flag = 0;
        repeat (15) begin
            wait_edges(1);
            if (switch_pending) flag = 1;
        end
        check("glitch_pending", flag, 0);
        check("glitch_mode", int'(mode_sync), 0);

        // Busy datapath holds the request
        @(negedge clk); aux_state = 1'b0; mode_req = 2'd1;
        wait_edges(7);
        flag = 0;
        repeat (23) begin
            if (!switch_pending || mode_sync != 2'd0) flag = 1;
            wait_edges(1);
        end
        check("busy_hold", flag, 0);
        @(negedge clk); aux_state = 1'b1;
        wait_edges(1);
        check("busy_release_mode", int'(mode_sync), 1);

`ifdef RF_MODE_CTRL_TIMEOUT_EN
        @(negedge clk); mode_req = 2'd0;
        wait_edges(10);
        @(negedge clk); aux_state = 1'b0; mode_req = 2'd1;
        wait_edges(7);
        check("tmo_pending", int'(switch_pending), 1);
        wait_edges(TIMEOUT - 1);
        check("tmo_mode_before", int'(mode_sync), 0);
        check("tmo_force_before", int'(force_switch), 0);
        wait_edges(1);
        check("tmo_mode", int'(mode_sync), 1);
        check("tmo_force", int'(force_switch), 1);
        wait_edges(1);
        check("tmo_force_end", int'(force_switch), 0);
        @(negedge clk); aux_state = 1'b1;
`endif

        // Entering stand-by keeps AUX high, then reset in the middle of the exit window
        @(negedge clk); mode_req = 2'd3;
        flag = 0;
        repeat (7) begin
            wait_edges(1);
            if (!aux_mode) flag = 1;
        end
        check("enter_stby_mode", int'(mode_sync), 3);
        check("enter_stby_aux", flag, 0);
        wait_edges(3);
        @(negedge clk); mode_req = 2'd0;
        wait_edges(7);
        check("sw_aux_low", int'(aux_mode), 0);
        wait_edges(5);
        @(negedge clk); rst_n = 1'b0;
        #1;
        check("midsw_rst_mode", int'(mode_sync), 3);
        check("midsw_rst_aux", int'(aux_mode), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_edges(INIT - 1);
        check("reinit_aux_low", int'(aux_mode), 0);
        wait_edges(1);
        check("reinit_aux_high", int'(aux_mode), 1);
        wait_edges(40);

        // Randomized pins and datapath idle
        hold = 0;
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if (hold == 0) begin
                mode_req = 2'($urandom_range(0, 3));
                hold = int'($urandom_range(1, 10));
            end
            hold--;
            if ($urandom_range(0, 31) == 0) aux_state = ~aux_state;
        end
        @(negedge clk);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
